// File: rtl/zube_mailbox.sv
// zube_mailbox: Wishbone-to-Z80 byte mailbox with RX/TX FIFOs, overflow flags and host IRQ
module zube_mailbox_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          ovf
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, rd_en, wr_en;

  assign full  = count == CW'(DEPTH);
  assign rd_en = pop & (count != '0);
  assign wr_en = push & (~full | rd_en);
  assign ovf   = push & full & ~rd_en;
  assign dout  = (count != '0) ? mem[rd_ptr] : '0;

  // byte storage, never reset; dout hides it while empty
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;

  // pointers wrap modulo DEPTH through their natural width
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count  <= count + CW'(wr_en) - CW'(rd_en);
    end
endmodule

module zube_mailbox #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        wb_cyc_in,
  input  logic        wb_stb_in,
  input  logic        wb_we_in,
  input  logic [31:0] wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic        wb_ack_out,
  output logic [31:0] wb_data_out,
  output logic        irq_out,
  input  logic        z_wr_strobe,
  input  logic [7:0]  z_data_in,
  input  logic        z_rd_strobe,
  output logic [7:0]  z_data_out,
  output logic        z_tx_valid,
  output logic        z_rx_full
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic sel, act, csr_wr, rx_pop, tx_push;
  logic rx_ovf_set, tx_ovf_set, rx_ovf, tx_ovf, irq_en, rx_ne, tx_full;
  logic [1:0] off;
  logic [7:0] rx_head;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [31:0] status, rdata;
  logic unused;

  assign unused  = ^{wb_addr_in[1:0], wb_data_in[31:8]};
  assign sel     = wb_cyc_in & wb_stb_in & (wb_addr_in[31:4] == BASE_ADDR[31:4]);
  assign act     = wb_ack_out & sel;
  assign off     = wb_addr_in[3:2];
  assign csr_wr  = act & wb_we_in;
  assign rx_pop  = act & ~wb_we_in & (off == 2'd0);
  assign tx_push = csr_wr & (off == 2'd0);

  zube_mailbox_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk(clk), .reset_b(reset_b), .push(z_wr_strobe), .pop(rx_pop), .din(z_data_in),
    .dout(rx_head), .count(rx_cnt), .ovf(rx_ovf_set)
  );

  zube_mailbox_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk(clk), .reset_b(reset_b), .push(tx_push), .pop(z_rd_strobe), .din(wb_data_in[7:0]),
    .dout(z_data_out), .count(tx_cnt), .ovf(tx_ovf_set)
  );

  assign rx_ne      = rx_cnt != '0;
  assign tx_full    = tx_cnt == CW'(DEPTH);
  assign z_tx_valid = tx_cnt != '0;
  assign z_rx_full  = rx_cnt == CW'(DEPTH);

  assign status = {11'b0, 5'(tx_cnt), 3'b0, 5'(rx_cnt), 4'b0, tx_ovf, rx_ovf, tx_full, rx_ne};
  assign rdata  = (off == 2'd0) ? {24'b0, rx_head} :
                  (off == 2'd1) ? status :
                  (off == 2'd2) ? {31'b0, irq_en} : '0;
  assign wb_data_out = wb_ack_out ? rdata : '0;

  // ack handshake, sticky overflow flags (set beats W1C), IRQ enable and registered IRQ
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      wb_ack_out <= 1'b0;
      rx_ovf     <= 1'b0;
      tx_ovf     <= 1'b0;
      irq_en     <= 1'b0;
      irq_out    <= 1'b0;
    end else begin
      wb_ack_out <= sel & ~wb_ack_out;
      rx_ovf     <= rx_ovf_set | (rx_ovf & ~(csr_wr & (off == 2'd1) & wb_data_in[2]));
      tx_ovf     <= tx_ovf_set | (tx_ovf & ~(csr_wr & (off == 2'd1) & wb_data_in[3]));
      irq_en     <= (csr_wr & (off == 2'd2)) ? wb_data_in[0] : irq_en;
      irq_out    <= irq_en & (rx_ne | rx_ovf);
    end
endmodule

// File: tb/tb_zube_mailbox.sv
// tb_zube_mailbox: table-driven and sequence checks of the mailbox with a read-data scoreboard
module tb_zube_mailbox;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 0, reset_b = 0;
  logic cyc = 0, stb = 0, we = 0;
  logic [31:0] addr = 0, wdat = 0;
  logic ack, irq;
  logic [31:0] rdat;
  logic z_wr_strobe = 0, z_rd_strobe = 0;
  logic [7:0] z_data_in = 0, z_data_out;
  logic z_tx_valid, z_rx_full;

  int vectors = 0, miscompares = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        w;
    logic [3:0]  o;
    logic [31:0] d;
    logic        chk;
    logic [31:0] e;
  } vec_t;
  vec_t tbl [$];

  zube_mailbox #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_b(reset_b),
    .wb_cyc_in(cyc), .wb_stb_in(stb), .wb_we_in(we),
    .wb_addr_in(addr), .wb_data_in(wdat),
    .wb_ack_out(ack), .wb_data_out(rdat), .irq_out(irq),
    .z_wr_strobe(z_wr_strobe), .z_data_in(z_data_in),
    .z_rd_strobe(z_rd_strobe), .z_data_out(z_data_out),
    .z_tx_valid(z_tx_valid), .z_rx_full(z_rx_full)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
    end
  endtask

  task automatic add(input logic w, input logic [3:0] o, input logic [31:0] d,
                     input logic chk, input logic [31:0] e);
    vec_t v;
    v.w = w; v.o = o; v.d = d; v.chk = chk; v.e = e;
    tbl.push_back(v);
  endtask

  // one Wishbone access; optional Z80 push lands in the ack cycle
  task automatic wb_acc(input logic w, input logic [3:0] o, input logic [31:0] d,
                        input logic chk, input logic [31:0] e,
                        input logic zp = 1'b0, input logic [7:0] zb = 8'h00);
    int n;
    logic [31:0] x;
    if (chk) exp_q.push_back(e);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = BASE + {28'b0, o}; wdat = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 16);
    check($sformatf("ack off%h", o), {31'b0, ack}, 1);
    if (ack) begin
      if (chk) begin
        x = exp_q.pop_front();
        check($sformatf("rdata off%h", o), rdat, x);
      end
      if (zp) begin z_wr_strobe = 1; z_data_in = zb; end
      @(posedge clk); #1;
      check("ack_pulse", {31'b0, ack} | rdat, 0);
      z_wr_strobe = 0;
    end else if (chk) void'(exp_q.pop_front());
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic z_push(input logic [7:0] b);
    @(negedge clk); z_wr_strobe = 1; z_data_in = b;
    @(negedge clk); z_wr_strobe = 0;
  endtask

  task automatic z_pop();
    @(negedge clk); z_rd_strobe = 1;
    @(negedge clk); z_rd_strobe = 0;
  endtask

  initial begin
    logic [7:0] txe [4];
    logic [7:0] rxe [5];
    int n, acks;
    txe[0] = 8'hA5; txe[1] = 8'h3C; txe[2] = 8'hC3; txe[3] = 8'h5A;

    repeat (3) @(negedge clk);
    check("reset_flags", {28'b0, ack, irq, z_tx_valid, z_rx_full}, 0);
    check("reset_dout", rdat | {24'b0, z_data_out}, 0);
    reset_b = 1;
    wb_acc(0, 4'h4, 0, 1, 32'h0);

    add(1, 4'h8, 32'h1, 0, 0);
    add(0, 4'h8, 0, 1, 32'h1);
    add(1, 4'h8, 32'hFFFF_FFFE, 0, 0);
    add(0, 4'h8, 0, 1, 32'h0);
    add(1, 4'hC, 32'h1234, 0, 0);
    add(0, 4'hC, 0, 1, 32'h0);
    add(1, 4'h0, 32'hA5, 0, 0);
    add(0, 4'h4, 0, 1, 32'h0001_0000);
    add(1, 4'h0, 32'h3C, 0, 0);
    add(1, 4'h0, 32'hC3, 0, 0);
    add(1, 4'h0, 32'h5A, 0, 0);
    add(0, 4'h4, 0, 1, 32'h0004_0002);
    add(1, 4'h0, 32'h77, 0, 0);
    add(0, 4'h4, 0, 1, 32'h0004_000A);
    add(0, 4'h0, 0, 1, 32'h0);
    add(1, 4'h4, 32'h4, 0, 0);
    add(0, 4'h4, 0, 1, 32'h0004_000A);
    foreach (tbl[i]) wb_acc(tbl[i].w, tbl[i].o, tbl[i].d, tbl[i].chk, tbl[i].e);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("tx_head%0d", i), {23'b0, z_tx_valid, z_data_out}, {23'b0, 1'b1, txe[i]});
      z_pop();
    end
    check("tx_empty", {23'b0, z_tx_valid, z_data_out}, 0);
    z_pop();
    check("tx_empty_pop", {23'b0, z_tx_valid, z_data_out}, 0);
    wb_acc(1, 4'h4, 32'h8, 0, 0);
    wb_acc(0, 4'h4, 0, 1, 32'h0);

    for (int i = 1; i <= 5; i++) z_push(8'(i));
    check("rx_full", {31'b0, z_rx_full}, 1);
    wb_acc(0, 4'h4, 0, 1, 32'h0000_0405);
    for (int i = 1; i <= 4; i++) wb_acc(0, 4'h0, 0, 1, 32'(i));
    wb_acc(0, 4'h0, 0, 1, 32'h0);
    check("rx_not_full", {31'b0, z_rx_full}, 0);
    wb_acc(0, 4'h4, 0, 1, 32'h0000_0004);
    wb_acc(1, 4'h4, 32'hC, 0, 0);
    wb_acc(0, 4'h4, 0, 1, 32'h0);

    wb_acc(0, 4'h0, 0, 1, 32'h0, 1, 8'hAB);
    wb_acc(0, 4'h4, 0, 1, 32'h0000_0101);
    wb_acc(0, 4'h0, 0, 1, 32'hAB);

    wb_acc(1, 4'h8, 32'h1, 0, 0);
    check("irq_idle", {31'b0, irq}, 0);
    @(negedge clk); z_wr_strobe = 1; z_data_in = 8'h99;
    @(posedge clk); #1;
    check("irq_lag", {31'b0, irq}, 0);
    z_wr_strobe = 0;
    @(posedge clk); #1;
    check("irq_set", {31'b0, irq}, 1);
    wb_acc(0, 4'h0, 0, 1, 32'h99);
    check("irq_hold", {31'b0, irq}, 1);
    @(posedge clk); #1;
    check("irq_clr", {31'b0, irq}, 0);

    rxe[0] = 8'h11; rxe[1] = 8'h22; rxe[2] = 8'h33; rxe[3] = 8'h44; rxe[4] = 8'h55;
    for (int i = 0; i < 5; i++) z_push(rxe[i]);
    wb_acc(0, 4'h4, 0, 1, 32'h0000_0405);
    wb_acc(1, 4'h4, 32'h4, 0, 0);
    wb_acc(0, 4'h4, 0, 1, 32'h0000_0401);
    wb_acc(1, 4'h4, 32'h4, 0, 0, 1, 8'h66);
    wb_acc(0, 4'h4, 0, 1, 32'h0000_0405);
    wb_acc(1, 4'h4, 32'h4, 0, 0);
    wb_acc(0, 4'h4, 0, 1, 32'h0000_0401);

    wb_acc(0, 4'h0, 0, 1, 32'h11, 1, 8'h77);
    wb_acc(0, 4'h4, 0, 1, 32'h0000_0401);
    wb_acc(0, 4'h0, 0, 1, 32'h22);
    wb_acc(0, 4'h0, 0, 1, 32'h33);
    wb_acc(0, 4'h0, 0, 1, 32'h44);
    wb_acc(0, 4'h0, 0, 1, 32'h77);
    wb_acc(0, 4'h0, 0, 1, 32'h0);

    @(negedge clk); cyc = 1; stb = 1; we = 0; addr = BASE + 32'h10;
    acks = 0;
    repeat (16) begin @(posedge clk); #1; acks += int'(ack); end
    check("oob_ack", 32'(acks), 0);
    cyc = 0; stb = 0;

    z_push(8'h5C);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("irq_pre_reset", {31'b0, irq}, 1);
    @(negedge clk); cyc = 1; stb = 1; we = 1; addr = BASE; wdat = 32'h5A;
    @(posedge clk); #1;
    check("ack_before_abort", {31'b0, ack}, 1);
    reset_b = 0; #1;
    check("rst_abort", {28'b0, ack, irq, z_tx_valid, z_rx_full}, 0);
    check("rst_dout", rdat, 0);
    #1 reset_b = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 16);
    check("ack_after_reset", {31'b0, ack}, 1);
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    check("tx_after_reset", {23'b0, z_tx_valid, z_data_out}, {23'b0, 1'b1, 8'h5A});
    wb_acc(0, 4'h4, 0, 1, 32'h0001_0000);
    wb_acc(0, 4'h8, 0, 1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
